// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the decryptor datapath.
// Holds the block constants, the FSM state encoding, GF(2^8) helpers,
// the forward/inverse S-box and the Rcon table.
// The S-boxes are written as functions: multiplicative inverse in GF(2^8)
// followed by (or preceded by) the FIPS-197 affine transform.
package aes_pkg;

  localparam int NR      = 10;
  localparam int BLOCK_W = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXPAND = 3'd1,
    INIT   = 3'd2,
    ROUND  = 3'd3,
    FINAL  = 3'd4
  } aes_state_e;

  // Multiply by x modulo 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (b[i] ? aa : 8'h00);
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), x);
    end
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Source byte index for InvShiftRows: byte i sits at row i%4, column i/4,
  // and row r is rotated right by r columns.
  function automatic int isr_src(input int i);
    return ((((i / 4) - (i % 4)) + 4) % 4) * 4 + (i % 4);
  endfunction

  // InvMixColumns on one column {a0,a1,a2,a3}, a0 in the top byte
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] m2, m4, m8;
    for (int j = 0; j < 4; j++) begin
      a[j]  = col[31 - 8 * j -: 8];
      m2    = xtime(a[j]);
      m4    = xtime(m2);
      m8    = xtime(m4);
      m9[j] = m8 ^ a[j];
      mb[j] = m8 ^ m2 ^ a[j];
      md[j] = m8 ^ m4 ^ a[j];
      me[j] = m8 ^ m4 ^ m2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse-cipher round, purely combinational.
// Ports: state_i (current state), rkey_i (round key), last_i (skip
// InvMixColumns for the final round), next_o (next state).
// next_o = InvMixColumns(InvSubBytes(InvShiftRows(state_i)) ^ rkey_i),
// or without InvMixColumns when last_i is set.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rkey_i,
  input  logic         last_i,
  output logic [127:0] next_o
);

  logic [BLOCK_W-1:0] ark_s;
  logic [BLOCK_W-1:0] mix_s;

  // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns per column
  always_comb begin
    ark_s = '0;
    mix_s = '0;
    for (int i = 0; i < 16; i++) begin
      ark_s[127 - 8 * i -: 8] = inv_sbox(state_i[127 - 8 * isr_src(i) -: 8])
                              ^ rkey_i[127 - 8 * i -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      mix_s[127 - 32 * c -: 32] = inv_mix_col(ark_s[127 - 32 * c -: 32]);
    end
  end

  assign next_o = last_i ? ark_s : mix_s;

endmodule

// File: rtl/aes_decryptor.sv
// Iterative AES-128 decryptor: 10-cycle key expansion, 1 initial
// AddRoundKey cycle, 9 full inverse rounds and 1 final round.
// Ports: clk, rst (async active-high), start (sampled in IDLE),
// ciphertext/key (bit 127 = byte 0), plaintext (held until next result),
// done (one-cycle pulse), busy (acceptance until done).
module aes_decryptor
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         done,
  output logic         busy
);

  aes_state_e         state_q;
  logic [3:0]         rnd_q;
  logic [BLOCK_W-1:0] st_q;
  logic [BLOCK_W-1:0] ct_q;
  logic [BLOCK_W-1:0] rk_q [0:NR];

  logic               rnd_ok_s;
  logic [3:0]         prev_idx_s;
  logic [3:0]         key_idx_s;
  logic [BLOCK_W-1:0] prev_rk_s;
  logic [BLOCK_W-1:0] new_rk_d;
  logic [BLOCK_W-1:0] inv_key_s;
  logic [BLOCK_W-1:0] inv_next_d;
  logic [31:0]        rot_s;
  logic [31:0]        temp_s;
  logic [31:0]        w0_s, w1_s, w2_s, w3_s;
  logic               last_s;

  // Next round key from the previous one; also selects the decrypt round key
  always_comb begin
    rnd_ok_s   = (rnd_q >= 4'd1) && (rnd_q <= 4'(NR));
    prev_idx_s = rnd_ok_s ? (rnd_q - 4'd1) : 4'd0;
    prev_rk_s  = rk_q[prev_idx_s];
    rot_s      = {prev_rk_s[23:0], prev_rk_s[31:24]};
    temp_s     = {sbox(rot_s[31:24]), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])}
               ^ {rcon(rnd_q), 24'h000000};
    w0_s       = prev_rk_s[127:96] ^ temp_s;
    w1_s       = prev_rk_s[95:64]  ^ w0_s;
    w2_s       = prev_rk_s[63:32]  ^ w1_s;
    w3_s       = prev_rk_s[31:0]   ^ w2_s;
    new_rk_d   = {w0_s, w1_s, w2_s, w3_s};
    key_idx_s  = (rnd_q <= 4'(NR)) ? rnd_q : 4'd0;
    inv_key_s  = rk_q[key_idx_s];
  end

  assign last_s = (state_q == FINAL);

  aes_inv_round u_inv_round (
    .state_i (st_q),
    .rkey_i  (inv_key_s),
    .last_i  (last_s),
    .next_o  (inv_next_d)
  );

  // Input latch and round-key file; contents only matter after EXPAND
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      ct_q     <= ciphertext;
      rk_q[0]  <= key;
    end else if (state_q == EXPAND && rnd_ok_s) begin
      rk_q[rnd_q] <= new_rk_d;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rnd_q     <= 4'd0;
      st_q      <= '0;
      plaintext <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= EXPAND;
            rnd_q   <= 4'd1;
            busy    <= 1'b1;
          end
        end
        EXPAND: begin
          if (!rnd_ok_s) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            busy    <= 1'b0;
          end else if (rnd_q == 4'(NR)) begin
            state_q <= INIT;          // rnd_q stays at 10 for INIT
          end else begin
            rnd_q   <= rnd_q + 4'd1;
          end
        end
        INIT: begin
          if (rnd_q != 4'(NR)) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            busy    <= 1'b0;
          end else begin
            st_q    <= ct_q ^ rk_q[NR];
            rnd_q   <= 4'd9;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          if (rnd_q == 4'd0 || rnd_q > 4'd9) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            busy    <= 1'b0;
          end else begin
            st_q <= inv_next_d;
            if (rnd_q == 4'd1) begin
              state_q <= FINAL;
              rnd_q   <= 4'd0;
            end else begin
              rnd_q   <= rnd_q - 4'd1;
            end
          end
        end
        FINAL: begin
          plaintext <= inv_next_d;
          done      <= 1'b1;
          busy      <= 1'b0;
          rnd_q     <= 4'd0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          rnd_q   <= 4'd0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decryptor.sv
// Directed bench for aes_decryptor: FIPS-197 vectors, latency/pulse timing,
// busy-start rejection, reset abort, back-to-back streaming and a random
// loopback through a forward AES-128 model kept in this bench.
module tb_aes_decryptor;
  import aes_pkg::*;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         done;
  logic         busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int           w_dones;
  int           w_first;
  int           w_second;
  logic [127:0] w_pt1;
  logic [127:0] w_pt2;

  aes_decryptor dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ciphertext (ciphertext),
    .key        (key),
    .plaintext  (plaintext),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_watch();
    w_dones  = 0;
    w_first  = -1;
    w_second = -1;
    w_pt1    = '0;
    w_pt2    = '0;
  endtask

  // Step cycles from_cyc..to_cyc (cycle n = after edge En), logging done pulses
  task automatic watch(input int from_cyc, input int to_cyc);
    for (int cyc = from_cyc; cyc <= to_cyc; cyc++) begin
      step();
      if (done === 1'b1) begin
        w_dones++;
        if (w_first < 0) begin
          w_first = cyc;
          w_pt1   = plaintext;
        end else if (w_second < 0) begin
          w_second = cyc;
          w_pt2    = plaintext;
        end
      end
    end
  endtask

  // Single operation: start pulse at E0, expect exactly one done at E21
  task automatic run_op(input string tag, input logic [127:0] k, input logic [127:0] c,
                        input logic [127:0] exp);
    clear_watch();
    key = k; ciphertext = c; start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_e0"}, busy, 128'd1);
    watch(1, 30);
    check({tag, "_done_cycle"}, w_first, 128'd21);
    check({tag, "_done_count"}, w_dones, 128'd1);
    check({tag, "_pt"}, w_pt1, exp);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward AES-128 encryption reference
  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] rk, s, t;
    logic [31:0]  w;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   sb [16];
    rk = k;
    s  = pt ^ k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      w = rk[31:0];
      w = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])} ^ {rc, 24'h000000};
      rk[127:96] = rk[127:96] ^ w;
      rk[95:64]  = rk[95:64]  ^ rk[127:96];
      rk[63:32]  = rk[63:32]  ^ rk[95:64];
      rk[31:0]   = rk[31:0]   ^ rk[63:32];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) sb[i] = sbox(s[127 - 8 * i -: 8]);
      for (int i = 0; i < 16; i++) t[127 - 8 * i -: 8] = sb[(((i / 4) + (i % 4)) % 4) * 4 + (i % 4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127 - 32 * c -: 8];
          a1 = t[119 - 32 * c -: 8];
          a2 = t[111 - 32 * c -: 8];
          a3 = t[103 - 32 * c -: 8];
          t[127 - 32 * c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                   xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
      end
      s = t ^ rk;
    end
    return s;
  endfunction

  initial begin
    logic [127:0] rk_key, rk_pt;

    // Reset state
    rst = 1'b1; start = 1'b0; key = '0; ciphertext = '0;
    step(); step();
    check("rst_busy", busy, 128'd0);
    check("rst_done", done, 128'd0);
    check("rst_pt", plaintext, 128'd0);
    rst = 1'b0;
    step();

    // C.1 with exact cycle timing and a start pulse on the FINAL edge (ignored)
    key = C1_KEY; ciphertext = C1_CT; start = 1'b1;
    step();
    start = 1'b0;
    check("c1_busy_e0", busy, 128'd1);
    repeat (20) step();
    check("c1_done_e20", done, 128'd0);
    check("c1_busy_e20", busy, 128'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("c1_done_e21", done, 128'd1);
    check("c1_busy_e21", busy, 128'd0);
    check("c1_pt_e21", plaintext, C1_PT);
    step();
    check("c1_done_e22", done, 128'd0);
    check("c1_start_on_done_busy", busy, 128'd0);
    step();
    check("c1_idle_e23_busy", busy, 128'd0);
    check("c1_pt_hold", plaintext, C1_PT);

    // Appendix B vector plus last round key
    run_op("appb", B_KEY, B_CT, B_PT);
    check("appb_rk10", dut.rk_q[10], B_RK10);

    // Input change and start while busy must not disturb the running op
    clear_watch();
    key = C1_KEY; ciphertext = C1_CT; start = 1'b1;
    step();
    start = 1'b0;
    watch(1, 4);
    key = B_KEY; ciphertext = B_CT; start = 1'b1;
    watch(5, 5);
    start = 1'b0;
    watch(6, 30);
    check("busy_start_done_cycle", w_first, 128'd21);
    check("busy_start_done_count", w_dones, 128'd1);
    check("busy_start_pt", w_pt1, C1_PT);

    // Reset during an operation aborts it
    clear_watch();
    key = C1_KEY; ciphertext = C1_CT; start = 1'b1;
    step();
    start = 1'b0;
    watch(1, 12);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 128'd0);
    check("abort_done", done, 128'd0);
    check("abort_pt", plaintext, 128'd0);
    step(); step();
    rst = 1'b0;
    watch(1, 25);
    check("abort_no_done", w_dones, 128'd0);
    run_op("after_rst", C1_KEY, C1_CT, C1_PT);

    // start held high: results every 22 cycles
    clear_watch();
    key = C1_KEY; ciphertext = C1_CT; start = 1'b1;
    step();
    watch(1, 49);
    start = 1'b0;
    check("stream_first_cycle", w_first, 128'd21);
    check("stream_second_cycle", w_second, 128'd43);
    check("stream_done_count", w_dones, 128'd2);
    check("stream_pt1", w_pt1, C1_PT);
    check("stream_pt2", w_pt2, C1_PT);
    watch(50, 70);
    check("stream_third_drain", w_dones, 128'd3);

    // Random loopback through the bench encryptor
    for (int n = 0; n < 100; n++) begin
      rk_key = {$urandom, $urandom, $urandom, $urandom};
      rk_pt  = {$urandom, $urandom, $urandom, $urandom};
      run_op("loopback", rk_key, enc(rk_pt, rk_key), rk_pt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
